// File: rtl/bcd_display_pkg.sv
// Shared types and the seven-segment decode table for the BCD display slice.
package bcd_display_pkg;

  localparam int NUM_DIGITS = 10;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [NUM_DIGITS-1:0] bcd_word_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  // Segment bit 0 is 'a', bit 6 is 'g'; non-decimal codes show nothing.
  function automatic seg_t seg_decode(input bcd_digit_t d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_bin2bcd.sv
// Iterative double-dabble converter: 32 shift cycles turn a 32-bit sample
// into 10 BCD digits, with o_done strobing for the one DONE cycle.
module bin2bcd
  import bcd_display_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_done,
  output bcd_word_t   o_bcd
);

  conv_state_t r_state;
  conv_state_t w_next;
  logic [31:0] r_sh;
  bcd_word_t   r_acc;
  bcd_word_t   w_adj;
  logic [4:0]  r_bitCnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_load) w_next = ST_SHIFT;
      ST_SHIFT: if (r_bitCnt == 5'd31) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != ST_IDLE);
    o_done = (r_state == ST_DONE);
  end

  // Add-3 correction is applied before each shift so no nibble exceeds 9 afterwards.
  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_acc[k] >= 4'd5) w_adj[k] = r_acc[k] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh     <= '0;
      r_acc    <= '0;
      r_bitCnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_sh     <= i_value;
            r_acc    <= '0;
            r_bitCnt <= '0;
          end
        end
        ST_SHIFT: begin
          {r_acc, r_sh} <= {w_adj, r_sh} << 1;
          r_bitCnt      <= r_bitCnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd = r_acc;

endmodule

// File: rtl/bcd_display.sv
// Samples a 32-bit counter value, converts it to BCD and scans it onto a
// 10-digit multiplexed seven-segment display with optional leading-zero blanking.
module bcd_display
  import bcd_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_value,
  input  logic                  i_load,
  output logic                  o_busy,
  output seg_t                  o_seg,
  output logic [NUM_DIGITS-1:0] o_an
);

  localparam int             PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PMAX = PW'(SCAN_DIV - 1);

  logic                  w_done;
  bcd_word_t             w_bcd;
  bcd_word_t             r_disp;
  logic [PW-1:0]         r_presc;
  logic [3:0]            r_idx;
  logic [NUM_DIGITS-1:0] w_blank;
  seg_t                  r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  bin2bcd u_conv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_value (i_value),
    .i_load  (i_load),
    .o_busy  (o_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_disp <= '0;
    else if (w_done) r_disp <= w_bcd;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PMAX) begin
      r_presc <= '0;
      r_idx   <= (r_idx == 4'(NUM_DIGITS - 1)) ? 4'd0 : r_idx + 4'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    logic v_allZero;
    w_blank   = '0;
    v_allZero = 1'b1;
    if (BLANK_LZ) begin
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        v_allZero  = v_allZero && (r_disp[k] == 4'd0);
        w_blank[k] = v_allZero;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg <= 7'h3F;
      r_an  <= NUM_DIGITS'(1);
    end else begin
      r_seg <= w_blank[r_idx] ? 7'h00 : seg_decode(r_disp[r_idx]);
      r_an  <= NUM_DIGITS'(1) << r_idx;
    end
  end

  assign o_seg = r_seg;
  assign o_an  = r_an;

endmodule

// File: tb/tb_bcd_display.sv
// Scoreboard bench: stimulus queues expected scans, a monitor checks busy
// length, per-digit segments and digit hold time for both blanking settings.
module tb_bcd_display;

  typedef logic [9:0][6:0] segs_t;

  typedef struct {
    bit    expBusy;
    segs_t exp0;
    segs_t exp1;
  } item_t;

  localparam segs_t Z0    = {10{7'h3F}};
  localparam segs_t Z1    = {{9{7'h00}}, 7'h3F};
  localparam segs_t E1    = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3F};
  localparam segs_t EMAX  = {7'h66, 7'h5B, 7'h6F, 7'h66, 7'h6F, 7'h7D, 7'h07, 7'h5B, 7'h6F, 7'h6D};
  localparam segs_t E42_0 = {{8{7'h3F}}, 7'h66, 7'h5B};
  localparam segs_t E42_1 = {{8{7'h00}}, 7'h66, 7'h5B};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        load;
  logic        busy0, busy1;
  logic [6:0]  seg0, seg1;
  logic [9:0]  an0, an1;

  item_t sb[$];
  item_t monItem;
  bit    monActive = 1'b0;
  int    testsRun  = 0;
  int    testsFailed = 0;

  always #5 clk = ~clk;

  bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load),
    .o_busy(busy0), .o_seg(seg0), .o_an(an0)
  );

  bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load),
    .o_busy(busy1), .o_seg(seg1), .o_an(an1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] v, input segs_t e0, input segs_t e1,
                               input bit doLoad);
    item_t it;
    it.expBusy = doLoad;
    it.exp0    = e0;
    it.exp1    = e1;
    if (doLoad) begin
      @(negedge clk);
      value = v;
      load  = 1'b1;
      sb.push_back(it);
      @(negedge clk);
      load  = 1'b0;
    end else begin
      sb.push_back(it);
    end
  endtask

  task automatic waitDone();
    @(negedge clk);
    wait (sb.size() == 0 && monActive == 1'b0);
  endtask

  // Monitor: each queued item is one conversion (or a plain scan) to verify.
  initial begin
    segs_t got0, got1;
    int    hold [10];
    int    cyc, len, goodHold;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        monItem   = sb.pop_front();
        monActive = 1'b1;
        if (monItem.expBusy) begin
          cyc = 0;
          while (!busy0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
          end
          if (!busy0) begin
            checkOutput("busyRise", 32'(busy0), 32'd1);
          end else begin
            len = 0;
            while (busy0 && len < 100) begin
              len++;
              @(negedge clk);
            end
            checkOutput("busyLen", 32'(len), 32'd33);
          end
        end
        repeat (3) @(negedge clk);
        got0 = '1;
        got1 = '1;
        for (int k = 0; k < 10; k++) hold[k] = 0;
        for (int s = 0; s < 40; s++) begin
          @(negedge clk);
          for (int k = 0; k < 10; k++) begin
            if (an0 == (10'd1 << k)) begin
              got0[k] = seg0;
              got1[k] = seg1;
              hold[k]++;
            end
          end
        end
        for (int k = 0; k < 10; k++) begin
          checkOutput($sformatf("segNoBlank_d%0d", k), 32'(got0[k]), 32'(monItem.exp0[k]));
          checkOutput($sformatf("segBlank_d%0d", k), 32'(got1[k]), 32'(monItem.exp1[k]));
        end
        goodHold = 0;
        for (int k = 0; k < 10; k++) if (hold[k] == 4) goodHold++;
        checkOutput("anHoldDigits", 32'(goodHold), 32'd10);
        monActive = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    repeat (2) @(negedge clk);
    checkOutput("rstAn",   32'(an0),   32'h001);
    checkOutput("rstSeg",  32'(seg0),  32'h3F);
    checkOutput("rstBusy", 32'(busy0), 32'd0);
    checkOutput("rstAnB",  32'(an1),   32'h001);
    checkOutput("rstSegB", 32'(seg1),  32'h3F);
    rst = 1'b0;

    applyStimulus(32'd0, Z0, Z1, 1'b0);
    waitDone();

    applyStimulus(32'd1234567890, E1, E1, 1'b1);
    waitDone();

    applyStimulus(32'hFFFFFFFF, EMAX, EMAX, 1'b1);
    waitDone();

    applyStimulus(32'd42, E42_0, E42_1, 1'b1);
    waitDone();

    applyStimulus(32'd0, Z0, Z1, 1'b1);
    waitDone();

    // A load arriving mid-conversion must neither restart nor alter the result.
    applyStimulus(32'd1234567890, E1, E1, 1'b1);
    repeat (9) @(negedge clk);
    value = 32'd42;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    value = 32'd7;
    waitDone();

    @(negedge clk);
    value = 32'hFFFFFFFF;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("busyAfterRst",  32'(busy0), 32'd0);
    checkOutput("busyAfterRstB", 32'(busy1), 32'd0);
    applyStimulus(32'd0, Z0, Z1, 1'b0);
    waitDone();

    applyStimulus(32'd42, E42_0, E42_1, 1'b1);
    waitDone();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bcd_display.md
# bcd_display

Display stage downstream of the 32-bit up/down counter unit. It samples the counter's `value` on request and converts it to 10 BCD digits with an iterative double-dabble engine. It then drives a 10-digit multiplexed seven-segment display, with optional leading-zero blanking. Digits are held stable between conversions, so the counter may keep running while the display shows the last sample.

## Interface
- `SCAN_DIV`, default 1000: clk cycles each digit is enabled; legal range ≥ 1.
- `BLANK_LZ`, default 1: 1 enables leading-zero blanking; 0 shows all digits.

- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `value`  in  32  unsigned binary input, from the counter's `value`.
- `load`  in  1  sample request; acted on only when not busy.
- `busy`  out  1  conversion in progress.
- `seg`  out  7  active-high segments; bit 0 = a … bit 6 = g.
- `an`  out  10  one-hot active-high digit enable; bit 0 = least-significant digit.

## Operation
- FSM states:
  - IDLE: if `load`, capture `value` into a 32-bit shift register, clear the 40-bit BCD accumulator and the bit counter, then go to SHIFT.
  - SHIFT: each cycle, every accumulator nibble ≥ 5 gets +3. Then {acc, sh} shifts left by 1. Runs exactly 32 cycles, then goes to DONE.
  - DONE: accumulator is copied into the 10×4-bit display register; go to IDLE.
- `busy` = 1 in SHIFT and DONE.
- `load` while busy is ignored; it is neither queued nor aborting.
- Accumulator width is 40 bits. The max input 4294967295 fits, so no overflow is possible.
- Scan prescaler:
  - Free-running count 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→…→9→0.
  - `an` = one-hot(index).
  - `seg` = decode(disp[index]), or 7'h00 if that digit is blanked.
- Blanking (BLANK_LZ=1): digit k ≥ 1 is blanked iff disp[k] and all digits above it are 0. Digit 0 is never blanked.
- Decode table:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
- Scanning is independent of conversion. The display register changes only on the DONE edge.

## Timing
- Reset values:
  - FSM IDLE, `busy`=0, display register all zeros
  - prescaler 0, index 0
  - `an`=10'h001, `seg`=7'h3F
- Reset mid-conversion aborts the conversion and clears the display register.
- Latency: with `load` sampled on edge t:
  - `busy`=1 from t+1.
  - SHIFT occupies cycles t+1..t+32; DONE is t+33.
  - New digits are visible from t+34; `busy`=0 from t+34.
  - Earliest next accepted `load` is at edge t+34.
- `seg` and `an` are registered, so they change together one cycle after the index or display register changes. There are no glitches between digits.
- `value` is sampled only at the accepting edge; later changes do not affect the conversion.

## Structure
- Package `bcd_display_pkg`:
  - `NUM_DIGITS`=10
  - `bcd_digit_t` (logic [3:0])
  - `bcd_word_t` (array of NUM_DIGITS digits)
  - `seg_t` (logic [6:0])
  - function `seg_decode(bcd_digit_t)`, returning 7'h00 for codes > 9.
- Sub-module `bin2bcd`: the FSM and double-dabble engine, with `load`/`busy`/`bcd` outputs.
- Top level: display register, prescaler, scanner and blanking.

## Test plan
- Reset: assert `rst` 2 cycles → `an`=001, `seg`=3F, `busy`=0; all 10 scanned digits show 3F with BLANK_LZ=0 and 7'h00 for digits 1..9 with BLANK_LZ=1.
- `value`=1234567890, 1-cycle `load`, SCAN_DIV=4:
  - `busy` is high for exactly 33 cycles.
  - Scan shows digit0=3F, d1=6F, d2=7F, d3=07, d4=7D, d5=6D, d6=66, d7=4F, d8=5B, d9=06.
  - Each `an` bit is held 4 cycles.
- `value`=32'hFFFFFFFF → digits 4294967295 (d9=66 … d0=6D).
- `value`=42, BLANK_LZ=1 → d0=5B, d1=66, d2..d9 `seg`=00. `value`=0 → d0=3F, others 00.
- `load` pulse at cycle 10 of a conversion with a different `value` → ignored; the result matches the first sample.
- `rst` at cycle 15 of a conversion → `busy`=0 next cycle; display all zero; a subsequent `load` converts correctly.
